// File: rtl/graf_pkg.sv
// Shared constants and FSM state type for the wiimote camera -> screen pen path.
package graf_pkg;

  localparam int CAM_W = 1024;
  localparam int CAM_H = 768;
  localparam int SCR_W = 640;
  localparam int SCR_H = 480;

  localparam logic [9:0] NO_BLOB = 10'd1023;

  // 1024 -> 640 and 768 -> 480 are both a 5/8 ratio
  localparam int SCALE_MUL   = 5;
  localparam int SCALE_SHIFT = 3;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    SCALE   = 2'd1,
    HOLD    = 2'd2
  } state_t;

endpackage

// File: rtl/blob_tracker_if.sv
// Sample-in / coordinate-out bundle between camera reader, blob_tracker and pixel_buffer.
interface blob_tracker_if;

  logic       in_valid;
  logic [9:0] x_in;
  logic [9:0] y_in;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] x_out;
  logic [8:0] y_out;
  logic       pen_down;
  logic       overrun;

  modport master (
    output in_valid, x_in, y_in, out_ready,
    input  out_valid, x_out, y_out, pen_down, overrun
  );

  modport slave (
    input  in_valid, x_in, y_in, out_ready,
    output out_valid, x_out, y_out, pen_down, overrun
  );

endinterface

// File: rtl/axis_average.sv
// One-axis window accumulator; presents (acc >> AVG_LOG2) * 5/8 combinationally.
module axis_average
  import graf_pkg::*;
#(
  parameter int AVG_LOG2 = 2,
  parameter int OUT_W    = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_add,
  input  logic [9:0]       i_data,
  output logic [OUT_W-1:0] o_scaled
);

  localparam int ACC_W = 10 + AVG_LOG2;

  logic [ACC_W-1:0] r_acc_p0;
  logic [9:0]       w_avg;

  // 13-bit product holds 1023*5; truncating shift keeps results within the screen
  function automatic logic [12:0] scale_5_8(input logic [9:0] avg);
    logic [12:0] prod;
    prod = 13'(avg) * 13'(SCALE_MUL);
    return prod >> SCALE_SHIFT;
  endfunction

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_acc_p0 <= '0;
    end else if (i_add) begin
      r_acc_p0 <= r_acc_p0 + ACC_W'(i_data);
    end
  end

  assign w_avg    = 10'(r_acc_p0 >> AVG_LOG2);
  assign o_scaled = OUT_W'(scale_5_8(w_avg));

endmodule

// File: rtl/blob_tracker.sv
// Averages wiimote blob samples, scales to 640x480, tracks pen presence.
// Optional macro MIRROR_X_EN mirrors x (639 - x) for a user-facing camera.
module blob_tracker
  import graf_pkg::*;
#(
  parameter int AVG_LOG2   = 2,
  parameter int LOST_LIMIT = 4
) (
  input logic           clk,
  input logic           reset,
  blob_tracker_if.slave bus
);

  localparam int WIN    = 1 << AVG_LOG2;
  localparam int CNT_W  = AVG_LOG2 + 1;
  localparam int LOST_W = 4;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [LOST_W-1:0] r_lost, w_lost_nxt, w_lost_sat;
  logic              r_out_valid, w_out_valid_nxt;
  logic              r_pen_down, w_pen_nxt;
  logic              r_overrun, w_overrun_nxt;
  logic [9:0]        r_x_out_p1;
  logic [8:0]        r_y_out_p1;

  logic       w_blob, w_noblob;
  logic       w_acc_add, w_acc_clr, w_load;
  logic [9:0] w_y_clamped;
  logic [9:0] w_x_scaled, w_x_final;
  logic [8:0] w_y_scaled;

  function automatic logic [9:0] clamp_y(input logic [9:0] y);
    return (y > 10'(CAM_H - 1)) ? 10'(CAM_H - 1) : y;
  endfunction

  assign w_blob      = bus.in_valid && (bus.y_in != NO_BLOB);
  assign w_noblob    = bus.in_valid && (bus.y_in == NO_BLOB);
  assign w_y_clamped = clamp_y(bus.y_in);
  assign w_lost_sat  = (r_lost == LOST_W'(LOST_LIMIT)) ? r_lost : r_lost + LOST_W'(1);

  // ---- stage p0: per-axis accumulation ----
  axis_average #(.AVG_LOG2(AVG_LOG2), .OUT_W(10)) u_avg_x (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (w_acc_clr),
    .i_add    (w_acc_add),
    .i_data   (bus.x_in),
    .o_scaled (w_x_scaled)
  );

  axis_average #(.AVG_LOG2(AVG_LOG2), .OUT_W(9)) u_avg_y (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (w_acc_clr),
    .i_add    (w_acc_add),
    .i_data   (w_y_clamped),
    .o_scaled (w_y_scaled)
  );

`ifdef MIRROR_X_EN
  assign w_x_final = 10'(SCR_W - 1) - w_x_scaled;
`else
  assign w_x_final = w_x_scaled;
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_lost_nxt      = r_lost;
    w_out_valid_nxt = r_out_valid;
    w_pen_nxt       = r_pen_down;
    w_overrun_nxt   = r_overrun;
    w_acc_add       = 1'b0;
    w_acc_clr       = 1'b0;
    w_load          = 1'b0;

    // No-blob samples age the lost counter in every state
    if (w_noblob) w_lost_nxt = w_lost_sat;

    unique case (r_state)
      COLLECT: begin
        if (w_blob) begin
          w_acc_add  = 1'b1;
          w_lost_nxt = '0;
          if (r_cnt == CNT_W'(WIN - 1)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = SCALE;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end else if (w_noblob) begin
          w_acc_clr = 1'b1;
          w_cnt_nxt = '0;
        end
      end
      SCALE: begin
        w_load          = 1'b1;
        w_acc_clr       = 1'b1;
        w_out_valid_nxt = 1'b1;
        w_pen_nxt       = 1'b1;
        w_state_nxt     = HOLD;
        if (w_blob) w_overrun_nxt = 1'b1;
      end
      HOLD: begin
        if (w_blob) w_overrun_nxt = 1'b1;
        if (r_out_valid && bus.out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_state_nxt     = COLLECT;
        end
      end
      default: w_state_nxt = COLLECT;
    endcase

    if (w_noblob && (w_lost_sat == LOST_W'(LOST_LIMIT))) w_pen_nxt = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= COLLECT;
      r_cnt       <= '0;
      r_lost      <= '0;
      r_out_valid <= 1'b0;
      r_pen_down  <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_lost      <= w_lost_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_pen_down  <= w_pen_nxt;
      r_overrun   <= w_overrun_nxt;
    end
  end

  // ---- stage p1: scaled coordinate register, held through HOLD ----
  always_ff @(posedge clk) begin
    if (reset) begin
      r_x_out_p1 <= '0;
      r_y_out_p1 <= '0;
    end else if (w_load) begin
      r_x_out_p1 <= w_x_final;
      r_y_out_p1 <= w_y_scaled;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.x_out     = r_x_out_p1;
  assign bus.y_out     = r_y_out_p1;
  assign bus.pen_down  = r_pen_down;
  assign bus.overrun   = r_overrun;

endmodule

// File: tb/tb_blob_tracker.sv
// Bench for blob_tracker: vector table of 4-sample windows plus hand sequences, scoreboard queue.
module tb_blob_tracker;

  logic clk;
  logic reset;

  blob_tracker_if bif();

  blob_tracker #(.AVG_LOG2(2), .LOST_LIMIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
  } exp_t;

  typedef struct packed {
    logic [3:0][9:0] xs;
    logic [3:0][9:0] ys;
    logic [9:0]      ex;
    logic [8:0]      ey;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[5];

  function automatic int mx(input int s);
`ifdef MIRROR_X_EN
    return 639 - s;
`else
    return s;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic send(input int x, input int y);
    bif.in_valid = 1'b1;
    bif.x_in     = 10'(x);
    bif.y_in     = 10'(y);
    tick();
    bif.in_valid = 1'b0;
  endtask

  task automatic push_exp(input int x, input int y);
    exp_t e;
    e.x = 10'(mx(x));
    e.y = 9'(y);
    sb.push_back(e);
  endtask

  task automatic expect_out(input string nm);
    exp_t e;
    chk({nm, "_valid"}, int'(bif.out_valid), 1);
    if (sb.size() == 0) begin
      n_chk++;
      n_err++;
      $display("FAIL %s_sb: output seen with empty scoreboard, x=%0d y=%0d", nm, bif.x_out, bif.y_out);
    end else begin
      e = sb.pop_front();
      chk({nm, "_x"}, int'(bif.x_out), int'(e.x));
      chk({nm, "_y"}, int'(bif.y_out), int'(e.y));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{xs: {4{10'd512}}, ys: {4{10'd384}}, ex: 10'd320, ey: 9'd240};
    vecs[1] = '{xs: {4{10'd1023}}, ys: {4{10'd900}}, ex: 10'd639, ey: 9'd479};
    vecs[2] = '{xs: {10'd300, 10'd200, 10'd100, 10'd0},
                ys: {10'd600, 10'd400, 10'd200, 10'd0}, ex: 10'd93, ey: 9'd187};
    vecs[3] = '{xs: {10'd5, 10'd3, 10'd2, 10'd1},
                ys: {10'd5, 10'd3, 10'd2, 10'd1}, ex: 10'd1, ey: 9'd1};
    vecs[4] = '{xs: {4{10'd1023}}, ys: {4{10'd767}}, ex: 10'd639, ey: 9'd479};

    bif.in_valid  = 1'b0;
    bif.x_in      = '0;
    bif.y_in      = '0;
    bif.out_ready = 1'b1;
    reset         = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    chk("rst_valid", int'(bif.out_valid), 0);
    chk("rst_x", int'(bif.x_out), 0);
    chk("rst_y", int'(bif.y_out), 0);
    chk("rst_pen", int'(bif.pen_down), 0);
    chk("rst_ovr", int'(bif.overrun), 0);

    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < 4; k++) send(int'(vecs[i].xs[k]), int'(vecs[i].ys[k]));
      chk($sformatf("v%0d_lat1", i), int'(bif.out_valid), 0);
      push_exp(int'(vecs[i].ex), int'(vecs[i].ey));
      tick();
      expect_out($sformatf("v%0d", i));
      chk($sformatf("v%0d_pen", i), int'(bif.pen_down), 1);
      tick();
      chk($sformatf("v%0d_done", i), int'(bif.out_valid), 0);
    end

    // Partial window discarded by a no-blob sample
    send(100, 100);
    send(100, 100);
    send(0, 1023);
    for (int k = 0; k < 3; k++) send(800, 400);
    chk("wrst_early", int'(bif.out_valid), 0);
    send(800, 400);
    push_exp(500, 250);
    tick();
    expect_out("wrst");
    tick();

    // Pen-up: a valid sample resets the lost count, four in a row drop the pen
    for (int k = 0; k < 3; k++) send(0, 1023);
    chk("pen_3lost", int'(bif.pen_down), 1);
    send(10, 10);
    chk("pen_valid", int'(bif.pen_down), 1);
    for (int k = 0; k < 3; k++) send(0, 1023);
    chk("pen_3lost_b", int'(bif.pen_down), 1);
    send(0, 1023);
    chk("pen_4lost", int'(bif.pen_down), 0);
    chk("pen_noout", int'(bif.out_valid), 0);

    // Backpressure: held output, dropped samples raise overrun
    bif.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) send(512, 384);
    push_exp(320, 240);
    tick();
    expect_out("bp");
    chk("bp_pen", int'(bif.pen_down), 1);
    chk("bp_ovr0", int'(bif.overrun), 0);
    for (int k = 0; k < 4; k++) send(0, 0);
    chk("bp_hold_valid", int'(bif.out_valid), 1);
    chk("bp_hold_x", int'(bif.x_out), mx(320));
    chk("bp_hold_y", int'(bif.y_out), 240);
    chk("bp_ovr1", int'(bif.overrun), 1);
    bif.out_ready = 1'b1;
    tick();
    chk("bp_release", int'(bif.out_valid), 0);
    for (int k = 0; k < 3; k++) send(800, 400);
    chk("bp_restart_early", int'(bif.out_valid), 0);
    send(800, 400);
    push_exp(500, 250);
    tick();
    expect_out("bp_restart");
    chk("bp_ovr_sticky", int'(bif.overrun), 1);
    tick();

    // Reset after three of four samples
    for (int k = 0; k < 3; k++) send(512, 384);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_valid", int'(bif.out_valid), 0);
    chk("mrst_x", int'(bif.x_out), 0);
    chk("mrst_y", int'(bif.y_out), 0);
    chk("mrst_pen", int'(bif.pen_down), 0);
    chk("mrst_ovr", int'(bif.overrun), 0);
    send(512, 384);
    chk("mrst_one_a", int'(bif.out_valid), 0);
    tick();
    chk("mrst_one_b", int'(bif.out_valid), 0);
    tick();
    chk("mrst_one_c", int'(bif.out_valid), 0);
    for (int k = 0; k < 3; k++) send(512, 384);
    chk("mrst_lat1", int'(bif.out_valid), 0);
    push_exp(320, 240);
    tick();
    expect_out("mrst");
    tick();
    chk("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
